vaudio_i2s_rx: RTL and testbench



---
 rtl/audio_pkg.sv | 17 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/vaudio_i2s_rx.sv | 158 +++++++++++++++
 tb/tb_vaudio_i2s_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, stereo frame layout and lock states.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] left;
        logic [AUDIO_SAMPLE_W-1:0] right;
    } frame_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ALIGN,
        ST_LOCKED
    } lock_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a pop frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_en;
    logic             wr_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop & ~empty;
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/vaudio_i2s_rx.sv
// I2S receiver: resynchronises VERA's LRCK/BCK/DATA into clk25 and
// delivers stereo frames through a small FIFO with lock/overflow status.
module vaudio_i2s_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk25,
    input  logic                rst,
    input  logic                i2s_bck,
    input  logic                i2s_lrck,
    input  logic                i2s_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                locked,
    output logic                overflow,
    output logic                short_err,
    input  logic                clr_status
);

    localparam int CW = $clog2(SAMPLE_W + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = 2 * SAMPLE_W;

    logic [1:0]          bck_s, lrck_s, data_s;
    logic                bck_h;
    logic                bck_rise, lrck, din;
    logic [SAMPLE_W-1:0] shreg, left_q, word;
    logic [CW-1:0]       bit_cnt;
    logic [TW-1:0]       wd_cnt;
    logic                lr_prev, primed, armed, left_pending;
    logic                boundary, word_short, short_evt, frame_evt;
    logic                wd_expire, push_q, pop, full, empty, ovf_evt;
    logic [FW-1:0]       push_frame, head;
    lock_state_t         state_q, state_d;

    assign bck_rise   = bck_s[1] & ~bck_h;
    assign lrck       = lrck_s[1];
    assign din        = data_s[1];
    assign word       = {shreg[SAMPLE_W-2:0], din};
    assign boundary   = bck_rise & primed & (lrck != lr_prev);
    assign word_short = bit_cnt < CW'(SAMPLE_W - 1);
    assign short_evt  = boundary & armed & word_short;
    assign frame_evt  = boundary & armed & ~word_short & lr_prev & left_pending;
    assign wd_expire  = (wd_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            bck_s  <= '0;
            lrck_s <= '0;
            data_s <= '0;
            bck_h  <= 1'b0;
        end else begin
            bck_s  <= {bck_s[0], i2s_bck};
            lrck_s <= {lrck_s[0], i2s_lrck};
            data_s <= {data_s[0], i2s_data};
            bck_h  <= bck_s[1];
        end
    end

    // The first edge only samples LRCK; the first word boundary only arms
    // the checker, so a partial word after reset is discarded quietly.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            left_q       <= '0;
            bit_cnt      <= '0;
            wd_cnt       <= '0;
            lr_prev      <= 1'b0;
            primed       <= 1'b0;
            armed        <= 1'b0;
            left_pending <= 1'b0;
            push_q       <= 1'b0;
            push_frame   <= '0;
        end else begin
            push_q <= frame_evt;
            if (frame_evt) push_frame <= {left_q, word};
            if (bck_rise) begin
                shreg   <= word;
                lr_prev <= lrck;
                primed  <= 1'b1;
                wd_cnt  <= '0;
                if (boundary) begin
                    bit_cnt <= '0;
                    armed   <= 1'b1;
                    if (armed) begin
                        if (!word_short && !lr_prev) begin
                            left_q       <= word;
                            left_pending <= 1'b1;
                        end else begin
                            left_pending <= 1'b0;
                        end
                    end
                end else if (bit_cnt != CW'(SAMPLE_W + 1)) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (wd_expire) begin
                left_pending <= 1'b0;
                bit_cnt      <= '0;
            end else begin
                wd_cnt <= wd_cnt + TW'(1);
            end
        end
    end

    assign pop     = out_valid & out_ready;
    assign ovf_evt = push_q & full & ~pop;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk25),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_frame),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = ~empty;
    assign out_left  = head[FW-1:SAMPLE_W];
    assign out_right = head[SAMPLE_W-1:0];

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            short_err <= 1'b0;
            state_q   <= ST_UNLOCKED;
        end else begin
            overflow  <= ovf_evt | (overflow & ~clr_status);
            short_err <= short_evt | (short_err & ~clr_status);
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (short_evt || wd_expire) begin
            state_d = ST_UNLOCKED;
        end else if (frame_evt) begin
            unique case (state_q)
                ST_UNLOCKED: state_d = ST_ALIGN;
                ST_ALIGN:    state_d = ST_LOCKED;
                default:     state_d = ST_LOCKED;
            endcase
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vaudio_i2s_rx.sv
// Directed bench for vaudio_i2s_rx: I2S bit stream at clk25/8 with
// hand-computed frames, status flags and timing.
module tb_vaudio_i2s_rx;
    import audio_pkg::*;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_bck = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_data = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_status = 1'b0;
    logic        out_valid, locked, overflow, short_err;
    logic [15:0] out_left, out_right;
    logic        carry = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    frame_t      exp_f;

    vaudio_i2s_rx dut (
        .clk25      (clk25),
        .rst        (rst),
        .i2s_bck    (i2s_bck),
        .i2s_lrck   (i2s_lrck),
        .i2s_data   (i2s_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_left   (out_left),
        .out_right  (out_right),
        .locked     (locked),
        .overflow   (overflow),
        .short_err  (short_err),
        .clr_status (clr_status)
    );

    always #5 clk25 = ~clk25;

    task automatic do_reset();
        rst = 1'b1;
        i2s_bck = 1'b0;
        i2s_lrck = 1'b0;
        i2s_data = 1'b0;
        out_ready = 1'b0;
        clr_status = 1'b0;
        carry = 1'b0;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        repeat (2) @(negedge clk25);
    endtask

    // One BCK period of 8 clk25 cycles, starting and ending on a negedge.
    task automatic send_bit(input logic lr, input logic d);
        i2s_bck = 1'b0;
        i2s_lrck = lr;
        i2s_data = d;
        repeat (4) @(negedge clk25);
        i2s_bck = 1'b1;
        repeat (4) @(negedge clk25);
    endtask

    // First edge carries the previous word's LSB (one-bit I2S delay).
    task automatic send_word(input logic lr, input logic [15:0] w, input int n);
        send_bit(lr, carry);
        for (int k = n - 1; k >= 1; k--) send_bit(lr, w[k]);
        carry = w[0];
    endtask

    task automatic flush();
        send_bit(1'b0, carry);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked got %b want 0", locked); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_vec++; if (short_err !== 1'b0) begin n_err++; $display("FAIL rst_short got %b want 0", short_err); end
        n_vec++; if ({out_left, out_right} !== 32'h0) begin n_err++; $display("FAIL rst_data got %h%h want 0", out_left, out_right); end
        do_reset();
    endtask

    task automatic test_standard();
        do_reset();
        send_word(1'b1, 16'h0000, 4);
        send_word(1'b0, 16'h1234, 16);
        send_word(1'b1, 16'hABCD, 16);
        i2s_bck = 1'b0;
        i2s_lrck = 1'b0;
        i2s_data = carry;
        repeat (4) @(negedge clk25);
        i2s_bck = 1'b1;
        repeat (3) @(posedge clk25);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat3_valid got %b want 0", out_valid); end
        @(posedge clk25);
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat4_valid got %b want 1", out_valid); end
        @(negedge clk25);
        repeat (3) @(negedge clk25);
        exp_f = '{left: 16'h1234, right: 16'hABCD};
        n_vec++; if ({out_left, out_right} !== exp_f) begin n_err++; $display("FAIL std_frame1 got %h%h want %h", out_left, out_right, exp_f); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL std_lock1 got %b want 0", locked); end
        out_ready = 1'b1;
        @(negedge clk25);
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL std_empty got %b want 0", out_valid); end
        send_word(1'b0, 16'h0F0F, 16);
        send_word(1'b1, 16'hF0F0, 16);
        flush();
        exp_f = '{left: 16'h0F0F, right: 16'hF0F0};
        n_vec++; if ({out_left, out_right} !== exp_f) begin n_err++; $display("FAIL std_frame2 got %h%h want %h", out_left, out_right, exp_f); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL std_lock2 got %b want 1", locked); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(1'b1, 16'h0000, 4);
        for (int i = 0; i < 6; i++) begin
            send_word(1'b0, 16'h1000 + 16'(i), 16);
            send_word(1'b1, 16'h2000 + 16'(i), 16);
        end
        flush();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            exp_f = '{left: 16'h1000 + 16'(i), right: 16'h2000 + 16'(i)};
            n_vec++; if ({out_valid, out_left, out_right} !== {1'b1, exp_f}) begin n_err++; $display("FAIL bp_drain%0d got %b %h%h want 1 %h", i, out_valid, out_left, out_right, exp_f); end
            out_ready = 1'b1;
            @(negedge clk25);
            out_ready = 1'b0;
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
        send_word(1'b0, 16'h3000, 16);
        send_word(1'b1, 16'h4000, 16);
        flush();
        exp_f = '{left: 16'h3000, right: 16'h4000};
        n_vec++; if ({out_valid, out_left, out_right} !== {1'b1, exp_f}) begin n_err++; $display("FAIL bp_new got %b %h%h want 1 %h", out_valid, out_left, out_right, exp_f); end
    endtask

    task automatic test_short();
        do_reset();
        send_word(1'b1, 16'h0000, 4);
        send_word(1'b0, 16'h3C3C, 10);
        send_word(1'b1, 16'h5A5A, 16);
        send_word(1'b0, 16'h1111, 16);
        n_vec++; if (short_err !== 1'b1) begin n_err++; $display("FAIL sh_flag got %b want 1", short_err); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL sh_lock got %b want 0", locked); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sh_nopush got %b want 0", out_valid); end
        send_word(1'b1, 16'h2222, 16);
        send_word(1'b0, 16'h3333, 16);
        send_word(1'b1, 16'h4444, 16);
        flush();
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL sh_relock got %b want 1", locked); end
        exp_f = '{left: 16'h1111, right: 16'h2222};
        n_vec++; if ({out_left, out_right} !== exp_f) begin n_err++; $display("FAIL sh_head got %h%h want %h", out_left, out_right, exp_f); end
        clr_status = 1'b1;
        @(negedge clk25);
        clr_status = 1'b0;
        n_vec++; if (short_err !== 1'b0) begin n_err++; $display("FAIL sh_clr got %b want 0", short_err); end
    endtask

    task automatic test_stall();
        do_reset();
        send_word(1'b1, 16'h0000, 4);
        send_word(1'b0, 16'hAAA1, 16);
        send_word(1'b1, 16'hBBB1, 16);
        send_word(1'b0, 16'hAAA2, 16);
        send_word(1'b1, 16'hBBB2, 16);
        flush();
        repeat (900) @(negedge clk25);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL st_before got %b want 1", locked); end
        repeat (200) @(negedge clk25);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL st_after got %b want 0", locked); end
        for (int i = 1; i <= 2; i++) begin
            exp_f = '{left: 16'hAAA0 + 16'(i), right: 16'hBBB0 + 16'(i)};
            n_vec++; if ({out_valid, out_left, out_right} !== {1'b1, exp_f}) begin n_err++; $display("FAIL st_pop%0d got %b %h%h want 1 %h", i, out_valid, out_left, out_right, exp_f); end
            out_ready = 1'b1;
            @(negedge clk25);
            out_ready = 1'b0;
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_empty got %b want 0", out_valid); end
    endtask

    task automatic test_start_right();
        do_reset();
        send_word(1'b1, 16'h5555, 7);
        send_word(1'b0, 16'h1357, 16);
        send_word(1'b1, 16'h2468, 16);
        flush();
        exp_f = '{left: 16'h1357, right: 16'h2468};
        n_vec++; if ({out_valid, out_left, out_right} !== {1'b1, exp_f}) begin n_err++; $display("FAIL sr_frame got %b %h%h want 1 %h", out_valid, out_left, out_right, exp_f); end
        n_vec++; if (short_err !== 1'b0) begin n_err++; $display("FAIL sr_short got %b want 0", short_err); end
        out_ready = 1'b1;
        @(negedge clk25);
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sr_single got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(1'b1, 16'h0000, 4);
        send_word(1'b0, 16'h0101, 16);
        send_word(1'b1, 16'h0202, 16);
        send_word(1'b0, 16'h0303, 16);
        send_word(1'b1, 16'h0404, 16);
        send_word(1'b0, 16'h7777, 16);
        send_word(1'b1, 16'h8888, 8);
        n_vec++; if ({out_valid, locked} !== 2'b11) begin n_err++; $display("FAIL rm_pre got %b%b want 11", out_valid, locked); end
        #3 rst = 1'b1;
        #1;
        n_vec++; if ({out_valid, locked, short_err} !== 3'b000) begin n_err++; $display("FAIL rm_async got %b%b%b want 000", out_valid, locked, short_err); end
        n_vec++; if ({out_left, out_right} !== 32'h0) begin n_err++; $display("FAIL rm_data got %h%h want 0", out_left, out_right); end
        @(negedge clk25);
        i2s_bck = 1'b0;
        i2s_lrck = 1'b0;
        i2s_data = 1'b0;
        repeat (2) @(negedge clk25);
        rst = 1'b0;
        repeat (2) @(negedge clk25);
        send_word(1'b1, 16'h9999, 5);
        send_word(1'b0, 16'h0A0A, 16);
        send_word(1'b1, 16'h0B0B, 16);
        send_word(1'b0, 16'h0C0C, 16);
        send_word(1'b1, 16'h0D0D, 16);
        flush();
        n_vec++; if (short_err !== 1'b0) begin n_err++; $display("FAIL rm_short got %b want 0", short_err); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL rm_lock got %b want 1", locked); end
        exp_f = '{left: 16'h0A0A, right: 16'h0B0B};
        n_vec++; if ({out_left, out_right} !== exp_f) begin n_err++; $display("FAIL rm_head got %h%h want %h", out_left, out_right, exp_f); end
    endtask

    initial begin
        @(negedge clk25);
        test_reset();
        test_standard();
        test_backpressure();
        test_short();
        test_stall();
        test_start_right();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
